// File: rtl/up3_control_unit.sv
// rtl/up3_control_unit.sv - UP3 processor control unit: Moore FSM sequencing fetch/decode/execute.
// Outputs decode the registered state (and the opcode latched at DECODE) only.
module up3_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] opcode,
  input  logic       ac_zero,
  output logic       fetch,
  output logic       incr_pc,
  output logic       load_pc,
  output logic       load_iru,
  output logic       load_irl,
  output logic       load_ac,
  output logic       store_mem,
  output logic       addr_sel,
  output logic [1:0] alu_sel,
  output logic       halted,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH_U  = 4'd1,
    S_LOAD_U   = 4'd2,
    S_FETCH_L  = 4'd3,
    S_LOAD_L   = 4'd4,
    S_DECODE   = 4'd5,
    S_EXEC_RD  = 4'd6,
    S_EXEC_AC  = 4'd7,
    S_EXEC_ST  = 4'd8,
    S_EXEC_JMP = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_STA = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_JZ  = 8'h05;
  localparam logic [7:0] OP_HLT = 8'hFF;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  state_t     cont_state;

  // Where a finished instruction goes: keep running or park in IDLE.
  assign cont_state = run ? S_FETCH_U : S_IDLE;

  always_comb begin
    state_d  = S_IDLE;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE: begin
        opcode_d = 8'h00;
        state_d  = run ? S_FETCH_U : S_IDLE;
      end
      S_FETCH_U: state_d = S_LOAD_U;
      S_LOAD_U:  state_d = S_FETCH_L;
      S_FETCH_L: state_d = S_LOAD_L;
      S_LOAD_L:  state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LDA, OP_ADD: state_d = S_EXEC_RD;
          OP_STA:         state_d = S_EXEC_ST;
          OP_JMP:         state_d = S_EXEC_JMP;
          OP_JZ:          state_d = ac_zero ? S_EXEC_JMP : cont_state;
          OP_HLT:         state_d = S_HALT;
          default:        state_d = cont_state;
        endcase
      end
      S_EXEC_RD:  state_d = S_EXEC_AC;
      S_EXEC_AC,
      S_EXEC_ST,
      S_EXEC_JMP: state_d = cont_state;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    fetch     = 1'b0;
    incr_pc   = 1'b0;
    load_pc   = 1'b0;
    load_iru  = 1'b0;
    load_irl  = 1'b0;
    load_ac   = 1'b0;
    store_mem = 1'b0;
    addr_sel  = 1'b0;
    alu_sel   = 2'b00;
    halted    = 1'b0;
    case (state_q)
      S_FETCH_U:  fetch = 1'b1;
      S_LOAD_U:   begin load_iru = 1'b1; incr_pc = 1'b1; end
      S_FETCH_L:  fetch = 1'b1;
      S_LOAD_L:   begin load_irl = 1'b1; incr_pc = 1'b1; end
      S_EXEC_RD:  begin fetch = 1'b1; addr_sel = 1'b1; end
      S_EXEC_AC: begin
        load_ac = 1'b1;
        alu_sel = (opcode_q == OP_ADD) ? 2'b01 : 2'b00;
      end
      S_EXEC_ST:  begin store_mem = 1'b1; addr_sel = 1'b1; end
      S_EXEC_JMP: load_pc = 1'b1;
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_up3_control_unit.sv
// tb/tb_up3_control_unit.sv - self-checking bench for up3_control_unit with an instruction-level model.
module tb_up3_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic       ac_zero = 1'b0;
  logic       fetch, incr_pc, load_pc, load_iru, load_irl, load_ac, store_mem, addr_sel, halted;
  logic [1:0] alu_sel;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int exp_seq[$];

  up3_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .ac_zero(ac_zero),
    .fetch(fetch), .incr_pc(incr_pc), .load_pc(load_pc), .load_iru(load_iru),
    .load_irl(load_irl), .load_ac(load_ac), .store_mem(store_mem), .addr_sel(addr_sel),
    .alu_sel(alu_sel), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {fetch, incr_pc, load_pc, load_iru, load_irl, load_ac, store_mem, addr_sel, alu_sel, halted};
  endfunction

  // Expected control word for a state, as listed per state in the output table.
  function automatic logic [10:0] exp_out(int st, logic [7:0] op);
    logic [10:0] v;
    v = '0;
    case (st)
      1, 3: v[10] = 1'b1;
      2:    begin v[7] = 1'b1; v[9] = 1'b1; end
      4:    begin v[6] = 1'b1; v[9] = 1'b1; end
      6:    begin v[10] = 1'b1; v[3] = 1'b1; end
      7:    begin v[5] = 1'b1; v[2:1] = (op == 8'h03) ? 2'b01 : 2'b00; end
      8:    begin v[4] = 1'b1; v[3] = 1'b1; end
      9:    v[8] = 1'b1;
      10:   v[0] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // Visible state trace of one instruction, starting at FETCH_U.
  task automatic build_seq(input logic [7:0] op, input logic z);
    exp_seq = '{1, 2, 3, 4, 5};
    case (op)
      8'h01, 8'h03: begin exp_seq.push_back(6); exp_seq.push_back(7); end
      8'h02: exp_seq.push_back(8);
      8'h04: exp_seq.push_back(9);
      8'h05: if (z) exp_seq.push_back(9);
      8'hFF: exp_seq.push_back(10);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state_dbg !== 4'd0) begin
        failures++; $display("FAIL reset_state cyc=%0d got=%0d exp=0", i, state_dbg);
      end
      checks++;
      if (obs() !== 11'd0) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%h exp=000", i, obs());
      end
      step();
    end
  endtask

  task automatic test_programs();
    logic [7:0] ops[8] = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h05, 8'h05, 8'h00, 8'h7A};
    logic       zs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int         lat[8] = '{7, 7, 6, 6, 6, 5, 5, 5};
    int k;
    run = 1'b1;
    step();
    for (int t = 0; t < 8; t++) begin
      opcode = ops[t]; ac_zero = zs[t];
      build_seq(ops[t], zs[t]);
      k = 0;
      do begin
        checks++;
        if (k >= exp_seq.size() || state_dbg !== 4'(exp_seq[k])) begin
          failures++; $display("FAIL prog_state op=%h k=%0d got=%0d", ops[t], k, state_dbg);
        end else begin
          checks++;
          if (obs() !== exp_out(exp_seq[k], ops[t])) begin
            failures++;
            $display("FAIL prog_outputs op=%h st=%0d got=%h exp=%h", ops[t], exp_seq[k], obs(), exp_out(exp_seq[k], ops[t]));
          end
        end
        step();
        k++;
      end while (state_dbg !== 4'd1 && k < 20);
      checks++;
      if (k !== lat[t]) begin
        failures++; $display("FAIL prog_latency op=%h got=%0d exp=%0d", ops[t], k, lat[t]);
      end
    end
  endtask

  task automatic test_halt();
    opcode = 8'hFF; run = 1'b1;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (state_dbg !== 4'd10 || obs() !== exp_out(10, 8'hFF)) begin
        failures++; $display("FAIL halt_hold cyc=%0d state=%0d out=%h exp_state=10", i, state_dbg, obs());
      end
      run = 1'($urandom);
      step();
    end
    reset = 1'b1; run = 1'b1;
    step();
    reset = 1'b0; run = 1'b0;
    checks++;
    if (state_dbg !== 4'd0 || obs() !== 11'd0) begin
      failures++; $display("FAIL halt_reset state=%0d out=%h exp=0/000", state_dbg, obs());
    end
  endtask

  task automatic test_mid_reset();
    run = 1'b1; opcode = 8'h01;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (state_dbg !== 4'd6) begin
      failures++; $display("FAIL midreset_reach got=%0d exp=6", state_dbg);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0;
    checks++;
    if (state_dbg !== 4'd0) begin
      failures++; $display("FAIL midreset_state got=%0d exp=0", state_dbg);
    end
  endtask

  task automatic test_run_drop();
    int tail[7] = '{3, 4, 5, 8, 0, 0, 0};
    run = 1'b1; opcode = 8'h02;
    step(); step();
    checks++;
    if (state_dbg !== 4'd2) begin
      failures++; $display("FAIL rundrop_reach got=%0d exp=2", state_dbg);
    end
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (state_dbg !== 4'(tail[i])) begin
        failures++; $display("FAIL rundrop_state i=%0d got=%0d exp=%0d", i, state_dbg, tail[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic       z, keep;
    int         r;
    reset = 1'b1; step(); reset = 1'b0;
    run = 1'b1; step();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      if (r <= 5) op = 8'(r);
      else if (r == 6) op = 8'(6 + $urandom_range(0, 248));
      else op = 8'h7A;
      z = 1'($urandom);
      keep = ($urandom_range(0, 3) != 0);
      build_seq(op, z);
      for (int i = 0; i < exp_seq.size(); i++) begin
        checks++;
        if (state_dbg !== 4'(exp_seq[i])) begin
          failures++; $display("FAIL rand_state n=%0d op=%h i=%0d got=%0d exp=%0d", n, op, i, state_dbg, exp_seq[i]);
        end
        checks++;
        if (obs() !== exp_out(exp_seq[i], op)) begin
          failures++; $display("FAIL rand_outputs n=%0d op=%h st=%0d got=%h exp=%h", n, op, exp_seq[i], obs(), exp_out(exp_seq[i], op));
        end
        checks++;
        if ((int'(fetch) + int'(store_mem) + int'(load_pc) + int'(load_ac)) > 1 || (incr_pc && load_pc)) begin
          failures++; $display("FAIL rand_exclusive n=%0d out=%h exp=onehot", n, obs());
        end
        opcode  = (i == 4) ? op : 8'($urandom);
        ac_zero = (i == 4) ? z : 1'($urandom);
        run     = (i == exp_seq.size() - 1) ? keep : 1'($urandom);
        step();
      end
      if (!keep) begin
        checks++;
        if (state_dbg !== 4'd0) begin
          failures++; $display("FAIL rand_idle n=%0d got=%0d exp=0", n, state_dbg);
        end
        run = 1'b1;
        step();
      end
    end
    checks++;
    if (state_dbg !== 4'd1) begin
      failures++; $display("FAIL rand_final got=%0d exp=1", state_dbg);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_programs();
    test_halt();
    test_mid_reset();
    test_run_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
